c17_resp_misr: RTL and testbench

- Downstream response-capture stage for the bit-level-pipelined c17 core.
- Consumes the core's two outputs (N22, N23) and tracks the stimulus-valid flag through a delay line that matches the core's pipeline latency.
- Compacts each aligned response into an 8-bit MISR over a programmed number of patterns, then reports the signature and pass/fail against a golden value.
- Sits between the core and the BIST/result-readout logic.

---
 rtl/c17_bist_pkg.sv | 42 ++++
 rtl/c17_resp_misr_if.sv | 45 ++++
 rtl/c17_resp_misr_vld_delay.sv | 46 ++++
 rtl/c17_resp_misr.sv | 118 +++++++++++
 tb/tb_c17_resp_misr.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/c17_bist_pkg.sv
// -----------------------------------------------------------------------------
// c17_bist_pkg
// Shared definitions for the c17 BIST slice (pattern side and response side).
//   state_t      : run-control states used by the response compactor
//   MISR_W       : signature register width
//   RESP_W       : width of the core response bus {N22,N23}
//   DEFAULT_POLY : MISR feedback taps, x^8+x^4+x^3+x^2+1
//   DEFAULT_SEED : signature value loaded when a run starts
//   misr_next()  : one compaction step of the signature register
// -----------------------------------------------------------------------------
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MISR_W = 8;
    localparam int RESP_W = 2;

    localparam logic [MISR_W-1:0] DEFAULT_POLY = 8'h1D;
    localparam logic [MISR_W-1:0] DEFAULT_SEED = 8'h00;

    // Galois-style step: shift left, fold the bit shifted out of the MSB
    // back through the tap mask, then XOR the new response into the LSBs.
    // Pure XOR/shift, so there are no carries anywhere in the datapath.
    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] sig,
        input logic [RESP_W-1:0] resp,
        input logic [MISR_W-1:0] poly
    );
        logic [MISR_W-1:0] feedback;
        logic [MISR_W-1:0] shifted;
        logic [MISR_W-1:0] injected;
        feedback = sig[MISR_W-1] ? poly : '0;
        shifted  = {sig[MISR_W-2:0], 1'b0};
        injected = {{(MISR_W-RESP_W){1'b0}}, resp};
        return shifted ^ feedback ^ injected;
    endfunction

endpackage

// File: rtl/c17_resp_misr_if.sv
// -----------------------------------------------------------------------------
// c17_resp_misr_if
// Groups the run-control, response and result signals of the response
// compactor.
//   start, in_valid, resp              : driven by the core / BIST controller
//   busy, done, pass, signature, count : driven by the compactor
// Modports:
//   master : the side that launches runs and feeds responses
//   slave  : the compactor itself
// -----------------------------------------------------------------------------
interface c17_resp_misr_if;
    import c17_bist_pkg::*;

    logic              start;
    logic              in_valid;
    logic [RESP_W-1:0] resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [MISR_W-1:0] signature;
    logic [7:0]        count;

    modport master (
        output start,
        output in_valid,
        output resp,
        input  busy,
        input  done,
        input  pass,
        input  signature,
        input  count
    );

    modport slave (
        input  start,
        input  in_valid,
        input  resp,
        output busy,
        output done,
        output pass,
        output signature,
        output count
    );

endinterface

// File: rtl/c17_resp_misr_vld_delay.sv
// -----------------------------------------------------------------------------
// vld_delay
// Parameterised single-bit shift register used to line a valid flag up with
// a pipelined datapath. Also usable by the upstream pattern-generator stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear of every stage
//   din   : flag entering the line
//   dout  : flag after DEPTH clock edges
// Parameters:
//   DEPTH : number of stages (>= 1)
// -----------------------------------------------------------------------------
module vld_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stages;

    // A depth-one line has no upper slice to shift, so it gets its own branch.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stages <= '0;
                end else begin
                    stages <= din;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/c17_resp_misr.sv
// -----------------------------------------------------------------------------
// c17_resp_misr
// Response-capture stage behind the bit-level-pipelined c17 core. A delay
// line matched to the core latency realigns the stimulus-valid flag with the
// {N22,N23} response; each aligned response is folded into an 8-bit MISR
// until N_PATTERNS responses are compacted, then the signature is compared
// against GOLDEN.
// Ports:
//   clk   : rising-edge clock shared with the core
//   rst_n : asynchronous active-low reset, aborts any run in progress
//   bus   : c17_resp_misr_if slave modport
//           start     - single-cycle pulse launching a run
//           in_valid  - stimulus presented to the core this cycle
//           resp      - {N22,N23} from the core
//           busy      - run in progress
//           done      - run finished, held until the next start
//           pass      - final signature matched GOLDEN (valid with done)
//           signature - current MISR contents
//           count     - responses compacted in the current run
// Parameters:
//   LATENCY    : core latency in clock edges, delay-line depth (>= 1)
//   N_PATTERNS : responses compacted per run (1..255)
//   POLY       : MISR feedback taps
//   SEED       : signature loaded on start
//   GOLDEN     : expected final signature
// -----------------------------------------------------------------------------
module c17_resp_misr
    import c17_bist_pkg::*;
#(
    parameter int                LATENCY    = 2,
    parameter int                N_PATTERNS = 32,
    parameter logic [MISR_W-1:0] POLY       = DEFAULT_POLY,
    parameter logic [MISR_W-1:0] SEED       = DEFAULT_SEED,
    parameter logic [MISR_W-1:0] GOLDEN     = 8'h00
) (
    input  logic           clk,
    input  logic           rst_n,
    c17_resp_misr_if.slave bus
);

    localparam logic [7:0] LAST_COUNT = 8'(N_PATTERNS);

    state_t            state;
    state_t            state_next;
    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_next;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_next;
    logic              pass_q;
    logic              pass_next;
    logic              rvld;

    // The delay line runs in every state; its output is the valid flag of
    // the response currently sitting on resp.
    vld_delay #(
        .DEPTH (LATENCY)
    ) u_vld_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.in_valid),
        .dout  (rvld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sig_q  <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_next;
            sig_q  <= sig_next;
            cnt_q  <= cnt_next;
            pass_q <= pass_next;
        end
    end

    // In IDLE and DONE a start takes priority over any response emerging
    // from the delay line, so that response is never compacted. The pass
    // flag is evaluated on the same edge as the final update, using the
    // freshly computed signature.
    always_comb begin
        state_next = state;
        sig_next   = sig_q;
        cnt_next   = cnt_q;
        pass_next  = pass_q;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    sig_next   = SEED;
                    cnt_next   = '0;
                    pass_next  = 1'b0;
                end
            end
            RUN: begin
                if (rvld) begin
                    sig_next = misr_next(sig_q, bus.resp, POLY);
                    cnt_next = cnt_q + 8'd1;
                    if (cnt_next == LAST_COUNT) begin
                        state_next = DONE;
                        pass_next  = (sig_next == GOLDEN);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.count     = cnt_q;

endmodule

// File: tb/tb_c17_resp_misr.sv
// -----------------------------------------------------------------------------
// tb_c17_resp_misr
// Drives one shared stimulus stream into three differently parameterised
// compactors and compares each against a reference model built from the
// response-alignment and MISR rules:
//   dut 0 : LATENCY 2, N_PATTERNS 4, SEED 00, GOLDEN 00
//   dut 1 : LATENCY 2, N_PATTERNS 1, SEED 80, GOLDEN 1D
//   dut 2 : LATENCY 3, N_PATTERNS 3, SEED 5A, GOLDEN 3C
// -----------------------------------------------------------------------------
module tb_c17_resp_misr;

    logic       clk;
    logic       rst_n;
    logic       start_s;
    logic       in_valid_s;
    logic [1:0] resp_s;

    int checks;
    int errors;

    c17_resp_misr_if ifa ();
    c17_resp_misr_if ifb ();
    c17_resp_misr_if ifc ();

    assign ifa.start    = start_s;
    assign ifa.in_valid = in_valid_s;
    assign ifa.resp     = resp_s;
    assign ifb.start    = start_s;
    assign ifb.in_valid = in_valid_s;
    assign ifb.resp     = resp_s;
    assign ifc.start    = start_s;
    assign ifc.in_valid = in_valid_s;
    assign ifc.resp     = resp_s;

    c17_resp_misr #(
        .LATENCY(2), .N_PATTERNS(4), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    c17_resp_misr #(
        .LATENCY(2), .N_PATTERNS(1), .POLY(8'h1D), .SEED(8'h80), .GOLDEN(8'h1D)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    c17_resp_misr #(
        .LATENCY(3), .N_PATTERNS(3), .POLY(8'h1D), .SEED(8'h5A), .GOLDEN(8'h3C)
    ) dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model parameters, one entry per instance.
    int         p_lat  [3] = '{2, 2, 3};
    int         p_npat [3] = '{4, 1, 3};
    logic [7:0] p_seed [3] = '{8'h00, 8'h80, 8'h5A};
    logic [7:0] p_gold [3] = '{8'h00, 8'h1D, 8'h3C};

    // Model state: running/finished flags, signature, count, pass.
    bit         m_running [3];
    bit         m_finished[3];
    logic [7:0] m_sig     [3];
    int         m_cnt     [3];
    bit         m_pass    [3];

    // Valid flag sampled at each clock edge since time zero; the response
    // seen at edge n belongs to the stimulus sampled at edge n-LATENCY,
    // provided that edge came after the most recent reset.
    bit vhist [0:8191];
    int cyc;
    int rst_base;

    function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [1:0] r);
        int v;
        v = (s * 2) % 256;
        if (s >= 8'd128) v = v ^ 8'h1D;
        v = v ^ int'(r);
        return 8'(v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_running[d]  = 0;
            m_finished[d] = 0;
            m_sig[d]      = 8'h00;
            m_cnt[d]      = 0;
            m_pass[d]     = 0;
        end
        rst_base = cyc;
    endtask

    task automatic model_edge(input bit st, input bit iv, input logic [1:0] r);
        bit rv;
        vhist[cyc] = iv;
        for (int d = 0; d < 3; d++) begin
            rv = 0;
            if (cyc - p_lat[d] >= rst_base) rv = vhist[cyc - p_lat[d]];
            if (!m_running[d]) begin
                if (st) begin
                    m_running[d]  = 1;
                    m_finished[d] = 0;
                    m_sig[d]      = p_seed[d];
                    m_cnt[d]      = 0;
                    m_pass[d]     = 0;
                end
            end else if (rv) begin
                m_sig[d] = ref_step(m_sig[d], r);
                m_cnt[d] = m_cnt[d] + 1;
                if (m_cnt[d] == p_npat[d]) begin
                    m_running[d]  = 0;
                    m_finished[d] = 1;
                    m_pass[d]     = (m_sig[d] == p_gold[d]);
                end
            end
        end
        cyc++;
    endtask

    function automatic logic [7:0] dut_sig(input int d);
        case (d)
            0:       return ifa.signature;
            1:       return ifb.signature;
            default: return ifc.signature;
        endcase
    endfunction

    function automatic logic [7:0] dut_cnt(input int d);
        case (d)
            0:       return ifa.count;
            1:       return ifb.count;
            default: return ifc.count;
        endcase
    endfunction

    function automatic logic dut_busy(input int d);
        case (d)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    function automatic logic dut_done(input int d);
        case (d)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic logic dut_pass(input int d);
        case (d)
            0:       return ifa.pass;
            1:       return ifb.pass;
            default: return ifc.pass;
        endcase
    endfunction

    // One clock of stimulus: inputs set after a falling edge, sampled by the
    // DUTs and the model on the rising edge, outputs observed at the next
    // falling edge.
    task automatic applyStimulus(input bit st, input bit iv, input logic [1:0] r);
        start_s    = st;
        in_valid_s = iv;
        resp_s     = r;
        @(posedge clk);
        model_edge(st, iv, r);
        @(negedge clk);
        start_s    = 1'b0;
        in_valid_s = 1'b0;
        resp_s     = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start_s    = 1'b0;
        in_valid_s = 1'b0;
        resp_s     = 2'b00;
        #2;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dut_busy(d) !== 1'b0 || dut_done(d) !== 1'b0 || dut_pass(d) !== 1'b0 ||
                dut_sig(d) !== 8'h00 || dut_cnt(d) !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_state dut%0d got busy=%b done=%b pass=%b sig=%h cnt=%h exp all zero",
                         d, dut_busy(d), dut_done(d), dut_pass(d), dut_sig(d), dut_cnt(d));
            end
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1, 0, 2'b00);
        repeat (3) applyStimulus(0, 1, 2'b11);
        checks++;
        if (ifa.busy !== 1'b1 || ifa.count !== 8'(m_cnt[0])) begin
            errors++;
            $display("[TB] FAIL midrun_busy got busy=%b cnt=%0d exp busy=1 cnt=%0d", ifa.busy, ifa.count, m_cnt[0]);
        end

        // Asynchronous abort: outputs must clear without any clock edge.
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dut_busy(d) !== 1'b0 || dut_done(d) !== 1'b0 ||
                dut_sig(d) !== 8'h00 || dut_cnt(d) !== 8'h00) begin
                errors++;
                $display("[TB] FAIL async_abort dut%0d got busy=%b done=%b sig=%h cnt=%h exp all zero",
                         d, dut_busy(d), dut_done(d), dut_sig(d), dut_cnt(d));
            end
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // The valids issued before the abort must not reappear.
        applyStimulus(1, 0, 2'b00);
        repeat (4) applyStimulus(0, 0, 2'b00);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (dut_cnt(d) !== 8'h00 || dut_busy(d) !== 1'b1) begin
                errors++;
                $display("[TB] FAIL delay_line_empty dut%0d got cnt=%0d busy=%b exp cnt=0 busy=1",
                         d, dut_cnt(d), dut_busy(d));
            end
        end
    endtask

    task automatic test_zero_responses();
        do_reset();
        applyStimulus(1, 0, 2'b00);
        repeat (4) applyStimulus(0, 1, 2'b00);
        applyStimulus(0, 0, 2'b00);
        checks++;
        if (ifa.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_done_early got done=%b exp 0", ifa.done);
        end
        applyStimulus(0, 0, 2'b00);
        checks++;
        if (ifa.done !== 1'b1 || ifa.count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL zero_done_latency got done=%b cnt=%0d exp done=1 cnt=4", ifa.done, ifa.count);
        end
        repeat (2) applyStimulus(0, 0, 2'b00);
        checks++;
        if (ifa.signature !== 8'h00 || ifa.pass !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_sig_a got sig=%h pass=%b exp sig=00 pass=1", ifa.signature, ifa.pass);
        end
        checks++;
        if (ifb.signature !== 8'h1D || ifb.pass !== 1'b1 || ifb.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_sig_b got sig=%h pass=%b done=%b exp sig=1d pass=1 done=1",
                     ifb.signature, ifb.pass, ifb.done);
        end
        checks++;
        if (ifc.signature !== m_sig[2] || ifc.done !== 1'b1 || ifc.pass !== m_pass[2]) begin
            errors++;
            $display("[TB] FAIL zero_sig_c got sig=%h done=%b pass=%b exp sig=%h done=1 pass=%b",
                     ifc.signature, ifc.done, ifc.pass, m_sig[2], m_pass[2]);
        end
    endtask

    task automatic test_accumulation();
        logic [7:0] seq [4] = '{8'h03, 8'h05, 8'h09, 8'h11};
        logic [7:0] prev_cnt;
        do_reset();
        applyStimulus(1, 0, 2'b00);
        prev_cnt = 8'h00;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, (i < 4), 2'b11);
            if (ifa.count !== prev_cnt && ifa.count >= 8'd1 && ifa.count <= 8'd4) begin
                checks++;
                if (ifa.signature !== seq[ifa.count - 8'd1]) begin
                    errors++;
                    $display("[TB] FAIL accum_step%0d got sig=%h exp %h",
                             ifa.count, ifa.signature, seq[ifa.count - 8'd1]);
                end
            end
            prev_cnt = ifa.count;
        end
        checks++;
        if (ifa.signature !== 8'h11 || ifa.pass !== 1'b0 || ifa.done !== 1'b1 || ifa.count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL accum_final got sig=%h pass=%b done=%b cnt=%0d exp sig=11 pass=0 done=1 cnt=4",
                     ifa.signature, ifa.pass, ifa.done, ifa.count);
        end
    endtask

    task automatic test_feedback();
        do_reset();
        applyStimulus(1, 0, 2'b00);
        applyStimulus(0, 1, 2'b00);
        repeat (3) applyStimulus(0, 0, 2'b00);
        checks++;
        if (ifb.signature !== 8'h1D || ifb.count !== 8'd1 || ifb.done !== 1'b1 || ifb.pass !== 1'b1) begin
            errors++;
            $display("[TB] FAIL feedback_tap got sig=%h cnt=%0d done=%b pass=%b exp sig=1d cnt=1 done=1 pass=1",
                     ifb.signature, ifb.count, ifb.done, ifb.pass);
        end
    endtask

    task automatic test_alignment();
        bit         pat [5] = '{1, 0, 0, 1, 1};
        logic [1:0] rs  [5];
        int         exp_cnt;
        do_reset();
        for (int j = 0; j < 5; j++) rs[j] = 2'($urandom_range(0, 3));
        applyStimulus(1, 0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, (i < 5) ? pat[i] : 1'b0, (i < 5) ? rs[i] : 2'b00);
            exp_cnt = 0;
            for (int j = 0; j < 5; j++) if (pat[j] && j + 3 <= i) exp_cnt++;
            if (exp_cnt > 3) exp_cnt = 3;
            checks++;
            if (ifc.count !== 8'(exp_cnt) || ifc.signature !== m_sig[2]) begin
                errors++;
                $display("[TB] FAIL align_tick%0d got cnt=%0d sig=%h exp cnt=%0d sig=%h",
                         i, ifc.count, ifc.signature, exp_cnt, m_sig[2]);
            end
        end
        checks++;
        if (ifc.done !== 1'b1 || ifc.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL align_done got done=%b busy=%b exp done=1 busy=0", ifc.done, ifc.busy);
        end
    endtask

    task automatic test_restart();
        logic [1:0] rs [4];
        logic [7:0] first_sig;
        do_reset();
        for (int j = 0; j < 4; j++) rs[j] = 2'($urandom_range(0, 3));
        applyStimulus(1, 0, 2'b00);
        applyStimulus(0, 1, rs[0]);
        applyStimulus(0, 1, rs[1]);
        applyStimulus(1, 1, rs[2]);
        checks++;
        if (ifa.busy !== 1'b1 || ifa.count !== 8'd1 || ifa.signature !== m_sig[0]) begin
            errors++;
            $display("[TB] FAIL start_in_run got busy=%b cnt=%0d sig=%h exp busy=1 cnt=1 sig=%h",
                     ifa.busy, ifa.count, ifa.signature, m_sig[0]);
        end
        applyStimulus(0, 1, rs[3]);
        repeat (3) applyStimulus(0, 0, 2'b00);
        first_sig = m_sig[0];
        checks++;
        if (ifa.done !== 1'b1 || ifa.signature !== first_sig || ifa.pass !== m_pass[0]) begin
            errors++;
            $display("[TB] FAIL restart_run1 got done=%b sig=%h pass=%b exp done=1 sig=%h pass=%b",
                     ifa.done, ifa.signature, ifa.pass, first_sig, m_pass[0]);
        end
        applyStimulus(1, 0, 2'b00);
        checks++;
        if (ifa.done !== 1'b0 || ifa.pass !== 1'b0 || ifa.signature !== 8'h00 ||
            ifa.count !== 8'd0 || ifa.busy !== 1'b1 || ifc.signature !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL restart_reload got done=%b pass=%b sig=%h cnt=%0d busy=%b sigc=%h exp 0 0 00 0 1 5a",
                     ifa.done, ifa.pass, ifa.signature, ifa.count, ifa.busy, ifc.signature);
        end
        for (int j = 0; j < 4; j++) applyStimulus(0, 1, rs[j]);
        repeat (3) applyStimulus(0, 0, 2'b00);
        checks++;
        if (ifa.done !== 1'b1 || ifa.signature !== first_sig || m_sig[0] !== first_sig) begin
            errors++;
            $display("[TB] FAIL restart_repeat got done=%b sig=%h exp done=1 sig=%h",
                     ifa.done, ifa.signature, first_sig);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (dut_sig(d) !== m_sig[d] || dut_cnt(d) !== 8'(m_cnt[d]) ||
                    dut_busy(d) !== m_running[d] || dut_done(d) !== m_finished[d] ||
                    (m_finished[d] && dut_pass(d) !== m_pass[d])) begin
                    errors++;
                    $display("[TB] FAIL random_c%0d_dut%0d got sig=%h cnt=%0d busy=%b done=%b pass=%b exp sig=%h cnt=%0d busy=%b done=%b pass=%b",
                             i, d, dut_sig(d), dut_cnt(d), dut_busy(d), dut_done(d), dut_pass(d),
                             m_sig[d], m_cnt[d], m_running[d], m_finished[d], m_pass[d]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_base = 0;
        $display("[TB] starting c17_resp_misr bench");
        test_reset();
        test_zero_responses();
        test_accumulation();
        test_feedback();
        test_alignment();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
